memory_system: RTL and testbench

Data-and-instruction memory subsystem directly downstream of the `cpu` top. It consumes the CPU's address bus, write enable and write data, and returns read data in the same cycle. It contains a word-addressed RAM and a small memory-mapped I/O window with an LED register, a countdown timer with auto-reload and interrupt flag, and a free-running cycle counter.

---
 rtl/memory_system_pkg.sv | 22 ++
 rtl/memory_system_if.sv | 21 ++
 rtl/memory_system_mmio_timer.sv | 91 +++++++++
 rtl/memory_system.sv | 105 ++++++++++
 tb/tb_memory_system.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/memory_system_pkg.sv
// Memory map constants shared by the memory subsystem: MMIO register
// offsets, timer control bit positions and the address-region decode type.
package mem_map_pkg;

    localparam logic [5:0] OFF_LED    = 6'h00;
    localparam logic [5:0] OFF_TCTRL  = 6'h04;
    localparam logic [5:0] OFF_TLOAD  = 6'h08;
    localparam logic [5:0] OFF_TCOUNT = 6'h0C;
    localparam logic [5:0] OFF_CYCLES = 6'h10;

    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_AUTO = 1;
    localparam int TCTRL_FLAG = 2;

    typedef enum logic [1:0] {REG_RAM, REG_GAP, REG_MMIO, REG_NONE} region_t;

    // Word-granular register match: byte-lane bits of the offset are ignored.
    function automatic logic reg_hit(input logic [3:0] word_off, input logic [5:0] reg_off);
        return word_off == reg_off[5:2];
    endfunction

endpackage

// File: rtl/memory_system_if.sv
// CPU-side memory bus: address, write strobe/data and combinational read data.
interface memory_system_if;
    logic [31:0] in_address;
    logic        in_mem_write_en;
    logic [31:0] in_mem_write_data;
    logic [31:0] out_mem_read_data;

    modport master (
        output in_address,
        output in_mem_write_en,
        output in_mem_write_data,
        input  out_mem_read_data
    );

    modport slave (
        input  in_address,
        input  in_mem_write_en,
        input  in_mem_write_data,
        output out_mem_read_data
    );
endinterface

// File: rtl/memory_system_mmio_timer.sv
// Countdown timer with auto-reload and a sticky terminal flag. Holds TCTRL,
// TLOAD and TCOUNT; exposes read-back values and the flag as irq.
module mmio_timer
    import mem_map_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_wr,
    input  logic        load_wr,
    input  logic [31:0] wdata,
    output logic [31:0] ctrl,
    output logic [31:0] load,
    output logic [31:0] count,
    output logic        irq
);

    logic        en, en_next;
    logic        auto_rl, auto_rl_next;
    logic        flag, flag_next;
    logic [31:0] load_val, load_next;
    logic [31:0] count_val, count_next;
    logic        terminal;

    assign terminal = en && (count_val == '0);

    // Next-state: countdown first, then register writes override, terminal set wins over clear
    always_comb begin
        en_next      = en;
        auto_rl_next = auto_rl;
        flag_next    = flag;
        load_next    = load_val;
        count_next   = count_val;

        if (en) begin
            if (count_val != '0) begin
                count_next = count_val - 32'd1;
            end else if (auto_rl) begin
                count_next = load_val;
            end else begin
                en_next = 1'b0;
            end
        end

        if (ctrl_wr) begin
            en_next      = wdata[TCTRL_EN];
            auto_rl_next = wdata[TCTRL_AUTO];
            if (wdata[TCTRL_FLAG]) begin
                flag_next = 1'b0;
            end
        end

        if (terminal) begin
            flag_next = 1'b1;
        end

        if (load_wr) begin
            load_next  = wdata;
            count_next = wdata;
        end
    end

    // Timer state registers; reset stops the timer at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en        <= 1'b0;
            auto_rl   <= 1'b0;
            flag      <= 1'b0;
            load_val  <= '0;
            count_val <= '0;
        end else begin
            en        <= en_next;
            auto_rl   <= auto_rl_next;
            flag      <= flag_next;
            load_val  <= load_next;
            count_val <= count_next;
        end
    end

    // Read-back view of TCTRL with unused bits as zero
    always_comb begin
        ctrl             = '0;
        ctrl[TCTRL_EN]   = en;
        ctrl[TCTRL_AUTO] = auto_rl;
        ctrl[TCTRL_FLAG] = flag;
    end

    assign load  = load_val;
    assign count = count_val;
    assign irq   = flag;

endmodule

// File: rtl/memory_system.sv
// Data/instruction memory subsystem: word RAM, address decode, LED and
// cycle-counter registers, timer instance and combinational read mux.
module memory_system
    import mem_map_pkg::*;
#(
    parameter int          RAM_WORDS = 1024,
    parameter string       INIT_FILE = "",
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic              clk,
    input  logic              reset,
    memory_system_if.slave    bus,
    output logic [15:0]       out_leds,
    output logic              out_timer_irq
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0] ram [RAM_WORDS];
    region_t     region;
    logic [AW-1:0] word;
    logic [3:0]  word_off;
    logic        mmio_wr;
    logic [15:0] led;
    logic [31:0] cycles;
    logic [31:0] rdata;
    logic [31:0] timer_ctrl, timer_load, timer_count;
    logic        addr_unused;

    assign word        = bus.in_address[AW+1:2];
    assign word_off    = bus.in_address[5:2];
    assign addr_unused = ^bus.in_address[1:0];

    // Region decode: RAM at the bottom, 64-byte MMIO window, gap in between
    always_comb begin
        region = REG_NONE;
        if (bus.in_address[31:AW+2] == '0) begin
            region = REG_RAM;
        end else if (bus.in_address[31:6] == MMIO_BASE[31:6]) begin
            region = REG_MMIO;
        end else if (bus.in_address < MMIO_BASE) begin
            region = REG_GAP;
        end
    end

    assign mmio_wr = bus.in_mem_write_en && (region == REG_MMIO);

    // RAM write port; contents survive reset but a write during reset is dropped
    always_ff @(posedge clk) begin
        if (bus.in_mem_write_en && (region == REG_RAM) && !reset) begin
            ram[word] <= bus.in_mem_write_data;
        end
    end

    // LED register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led <= '0;
        end else if (mmio_wr && reg_hit(word_off, OFF_LED)) begin
            led <= bus.in_mem_write_data[15:0];
        end
    end

    // Free-running cycle counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles <= '0;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    mmio_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .ctrl_wr (mmio_wr && reg_hit(word_off, OFF_TCTRL)),
        .load_wr (mmio_wr && reg_hit(word_off, OFF_TLOAD)),
        .wdata   (bus.in_mem_write_data),
        .ctrl    (timer_ctrl),
        .load    (timer_load),
        .count   (timer_count),
        .irq     (out_timer_irq)
    );

    // Combinational read mux; gap, unmapped offsets and out-of-window reads are zero
    always_comb begin
        rdata = '0;
        case (region)
            REG_RAM: rdata = ram[word];
            REG_MMIO: begin
                if (reg_hit(word_off, OFF_LED))         rdata = {16'h0000, led};
                else if (reg_hit(word_off, OFF_TCTRL))  rdata = timer_ctrl;
                else if (reg_hit(word_off, OFF_TLOAD))  rdata = timer_load;
                else if (reg_hit(word_off, OFF_TCOUNT)) rdata = timer_count;
                else if (reg_hit(word_off, OFF_CYCLES)) rdata = cycles;
                else                                    rdata = '0;
            end
            default: rdata = '0;
        endcase
    end

    assign bus.out_mem_read_data = rdata;
    assign out_leds              = led;

endmodule

// File: tb/tb_memory_system.sv
// Scoreboard bench for memory_system: the driver issues one bus cycle per
// clock and queues the expected responses; a monitor on the falling edge
// pops and compares them against the DUT outputs.
module tb_memory_system;

    localparam logic [31:0] MB = 32'hFFFF_0000;
    localparam logic [31:0] A_LED = MB + 32'h00;
    localparam logic [31:0] A_TC  = MB + 32'h04;
    localparam logic [31:0] A_TL  = MB + 32'h08;
    localparam logic [31:0] A_CN  = MB + 32'h0C;
    localparam logic [31:0] A_CY  = MB + 32'h10;

    localparam int K_RD  = 0;
    localparam int K_LED = 1;
    localparam int K_IRQ = 2;

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] exp;
    } item_t;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] out_leds;
    logic out_timer_irq;

    memory_system_if bus();

    item_t sb[$];
    int passed = 0;
    int total  = 0;

    memory_system #(
        .RAM_WORDS (1024),
        .INIT_FILE (""),
        .MMIO_BASE (MB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .out_leds      (out_leds),
        .out_timer_irq (out_timer_irq)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [31:0] a, input logic we, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.in_address        = a;
        bus.in_mem_write_en   = we;
        bus.in_mem_write_data = d;
    endtask

    task automatic ex(input int kind, input string name, input logic [31:0] v);
        item_t it;
        it.kind = kind;
        it.name = name;
        it.exp  = v;
        sb.push_back(it);
    endtask

    // Monitor: drain every expectation queued for the current bus cycle
    always @(negedge clk) begin
        item_t it;
        logic [31:0] act;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            case (it.kind)
                K_LED:   act = {16'h0000, out_leds};
                K_IRQ:   act = {31'h0, out_timer_irq};
                default: act = bus.out_mem_read_data;
            endcase
            total++;
            if (act === it.exp) passed++;
            else $display("FAIL %s: got %08h expected %08h", it.name, act, it.exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.in_address        = '0;
        bus.in_mem_write_en   = 1'b0;
        bus.in_mem_write_data = '0;

        // Reset state
        step(A_LED, 0, 0); ex(K_RD, "rst_led_rd", 0); ex(K_LED, "rst_leds", 0); ex(K_IRQ, "rst_irq", 0);
        step(A_CY, 0, 0);  ex(K_RD, "rst_cycles", 0);
        step(A_TC, 0, 0);  ex(K_RD, "rst_tctrl", 0);
        step(A_CY, 0, 0);  reset = 1'b0; ex(K_RD, "cyc_first", 0);
        step(A_CY, 0, 0);  ex(K_RD, "cyc_second", 1);

        // RAM write/read, read-during-write
        step(32'h0, 1, 32'hA0A0_A0A0);
        step(32'h14, 1, 32'h1111_1111);
        step(32'h14, 1, 32'h2222_2222); ex(K_RD, "rdw_old", 32'h1111_1111);
        step(32'h14, 0, 0);             ex(K_RD, "rdw_new", 32'h2222_2222);
        step(32'h10, 1, 32'hDEAD_BEEF);
        step(32'h10, 0, 0); ex(K_RD, "ram_10", 32'hDEAD_BEEF);
        step(32'h13, 0, 0); ex(K_RD, "ram_13", 32'hDEAD_BEEF);

        // Gap, unmapped offset, above window
        step(32'h1000, 1, 32'h1234);
        step(32'h1000, 0, 0);       ex(K_RD, "gap_rd", 0);
        step(MB + 32'h20, 1, 32'h1234);
        step(MB + 32'h20, 0, 0);    ex(K_RD, "unmapped_rd", 0);
        step(MB + 32'h40, 1, 32'h1234);
        step(MB + 32'h40, 0, 0);    ex(K_RD, "above_rd", 0);
        step(32'h0, 0, 0);          ex(K_RD, "ram0_kept", 32'hA0A0_A0A0);

        // LED
        step(A_LED, 1, 32'hFFFF_A5A5); ex(K_LED, "led_pre", 0);
        step(A_LED, 0, 0);  ex(K_LED, "led_post", 32'hA5A5); ex(K_RD, "led_rd", 32'h0000_A5A5);
        step(MB + 32'h2, 0, 0); ex(K_RD, "led_rd_lowbits", 32'h0000_A5A5);

        // One-shot timer: TLOAD=3, EN
        step(A_TL, 1, 3);
        step(A_TC, 1, 1);
        step(A_CN, 0, 0); ex(K_RD, "os_cnt3", 3); ex(K_IRQ, "os_irq_a", 0);
        step(A_CN, 0, 0); ex(K_RD, "os_cnt2", 2);
        step(A_CN, 0, 0); ex(K_RD, "os_cnt1", 1);
        step(A_CN, 0, 0); ex(K_RD, "os_cnt0", 0); ex(K_IRQ, "os_irq_b", 0);
        step(A_TC, 0, 0); ex(K_RD, "os_tctrl", 4); ex(K_IRQ, "os_irq_set", 1);
        step(A_CN, 0, 0); ex(K_RD, "os_cnt_hold", 0);
        step(A_TL, 0, 0); ex(K_RD, "os_tload", 3);
        step(A_TC, 1, 4); ex(K_IRQ, "os_irq_hold", 1);
        step(A_TC, 0, 0); ex(K_IRQ, "os_irq_clr", 0); ex(K_RD, "os_tctrl_clr", 0);
        step(A_CN, 1, 99);
        step(A_CN, 0, 0); ex(K_RD, "tcount_ro", 0);

        // Auto-reload, clear vs terminal, TLOAD write vs terminal
        step(A_TL, 1, 2);
        step(A_TC, 1, 3);
        step(A_CN, 0, 0); ex(K_RD, "ar_cnt2", 2);
        step(A_CN, 0, 0); ex(K_RD, "ar_cnt1", 1);
        step(A_CN, 0, 0); ex(K_RD, "ar_cnt0", 0); ex(K_IRQ, "ar_irq_a", 0);
        step(A_TC, 1, 7); ex(K_RD, "ar_tctrl7", 7); ex(K_IRQ, "ar_irq_set", 1);
        step(A_CN, 0, 0); ex(K_RD, "ar_cnt1b", 1); ex(K_IRQ, "ar_irq_clr", 0);
        step(A_TC, 1, 7); ex(K_RD, "ar_tctrl3", 3);
        step(A_CN, 0, 0); ex(K_RD, "ar_reload", 2); ex(K_IRQ, "set_wins", 1);
        step(A_TC, 1, 7); ex(K_IRQ, "ar_irq_c", 1);
        step(A_TL, 1, 5); ex(K_IRQ, "ar_irq_d", 0);
        step(A_CN, 0, 0); ex(K_RD, "tload_wins", 5); ex(K_IRQ, "tload_flag", 1);
        step(A_CN, 0, 0); ex(K_RD, "ar_cnt4", 4);

        // Reset mid-count
        step(A_CN, 0, 0); reset = 1'b1;
        ex(K_RD, "mid_rst_cnt", 0); ex(K_IRQ, "mid_rst_irq", 0); ex(K_LED, "mid_rst_leds", 0);
        step(A_CY, 0, 0);  ex(K_RD, "mid_rst_cyc", 0);
        step(A_TC, 0, 0);  ex(K_RD, "mid_rst_tctrl", 0);
        step(32'h10, 0, 0); ex(K_RD, "ram_after_rst", 32'hDEAD_BEEF);
        step(A_TC, 0, 0);  reset = 1'b0; ex(K_RD, "post_rst_tctrl", 0);
        step(A_CN, 0, 0);  ex(K_RD, "post_rst_cnt", 0);

        // TLOAD=0 auto: terminal each cycle; TCTRL write EN=0 wins
        step(A_TL, 1, 0);
        step(A_TC, 1, 3);
        step(A_TC, 0, 0); ex(K_RD, "z_tctrl3", 3);
        step(A_TC, 1, 6); ex(K_RD, "z_tctrl7", 7);
        step(A_TC, 0, 0); ex(K_RD, "en_write_wins", 6);
        step(A_TC, 0, 0); ex(K_RD, "z_stopped", 6);

        @(negedge clk);
        #1;
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL sb_drain: got %0d expected 0 pending", sb.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
